// File: rtl/animator_fade.sv
// Per-frame fade engine: sweeps every channel, reads target and current values,
// moves current toward target by the latched mode/step/shift and writes it back.
module animator_fade #(
    parameter int c_ledboards = 30,
    parameter int c_channels  = c_ledboards * 32,
    parameter int c_addr_w    = $clog2(c_channels),
    parameter int c_bpc       = 12,
    parameter int c_rd_lat    = 1,
    parameter int c_shift_w   = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_drq,
    input  logic [1:0]           i_mode,
    input  logic [c_bpc-1:0]     i_step,
    input  logic [c_shift_w-1:0] i_shift,
    input  logic [c_bpc-1:0]     i_target_data,
    input  logic [c_bpc-1:0]     i_current_data,
    output logic [c_addr_w-1:0]  o_addr,
    output logic                 o_current_wen,
    output logic [c_bpc-1:0]     o_current_data,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_overrun
);

    // state   | meaning
    // S_IDLE  | wait for i_drq, o_addr holds last address
    // S_READ  | o_addr presented, wait c_rd_lat cycles for buffer data
    // S_CALC  | read data valid, compute next value into the write register
    // S_WRITE | write pulse to current buffer, advance or finish
    typedef enum logic [1:0] {S_IDLE, S_READ, S_CALC, S_WRITE} state_t;

    localparam int c_lat_w = (c_rd_lat > 1) ? $clog2(c_rd_lat) : 1;
    localparam logic [c_lat_w-1:0] c_lat_load = c_lat_w'(c_rd_lat - 1);

    state_t               state, state_nxt;
    logic [c_lat_w-1:0]   lat_cnt;
    logic [1:0]           mode_q;
    logic [c_bpc-1:0]     step_q;
    logic [c_shift_w-1:0] shift_q;
    logic                 lat_tc, last_ch;

    logic [c_bpc:0]       diff;
    logic                 up;
    logic [c_bpc-1:0]     mag, exp_d, delta, next_val;

    assign lat_tc  = (lat_cnt == '0);
    assign last_ch = (o_addr == c_addr_w'(c_channels - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (i_drq) state_nxt = S_READ;
            S_READ:  if (lat_tc) state_nxt = S_CALC;
            S_CALC:  state_nxt = S_WRITE;
            S_WRITE: state_nxt = last_ch ? S_IDLE : S_READ;
            default: state_nxt = S_IDLE;
        endcase
    end

    // delta never exceeds |diff|, so next stays between current and target
    always_comb begin
        delta = '0;
        diff  = {1'b0, i_target_data} - {1'b0, i_current_data};
        up    = ~diff[c_bpc];
        mag   = diff[c_bpc] ? (i_current_data - i_target_data) : diff[c_bpc-1:0];
        exp_d = mag >> shift_q;
        if (exp_d == '0 && mag != '0) exp_d = c_bpc'(1);
        case (mode_q)
            2'd0:    delta = (step_q < mag) ? step_q : mag;
            2'd1:    delta = mag;
            2'd2:    delta = exp_d;
            default: delta = '0;
        endcase
        next_val = up ? (i_current_data + delta) : (i_current_data - delta);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_addr         <= '0;
            o_current_wen  <= 1'b0;
            o_current_data <= '0;
            o_busy         <= 1'b0;
            o_done         <= 1'b0;
            o_overrun      <= 1'b0;
            lat_cnt        <= '0;
            mode_q         <= '0;
            step_q         <= '0;
            shift_q        <= '0;
        end else begin
            o_current_wen <= 1'b0;
            o_done        <= 1'b0;
            o_overrun     <= i_drq & o_busy;
            case (state)
                S_IDLE: begin
                    if (i_drq) begin
                        mode_q  <= i_mode;
                        step_q  <= i_step;
                        shift_q <= i_shift;
                        o_addr  <= '0;
                        lat_cnt <= c_lat_load;
                        o_busy  <= 1'b1;
                    end
                end
                S_READ: begin
                    if (!lat_tc) lat_cnt <= lat_cnt - 1'b1;
                end
                S_CALC: begin
                    o_current_data <= next_val;
                    o_current_wen  <= 1'b1;
                end
                S_WRITE: begin
                    if (last_ch) begin
                        o_done <= 1'b1;
                        o_busy <= 1'b0;
                    end else begin
                        o_addr  <= o_addr + 1'b1;
                        lat_cnt <= c_lat_load;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_animator_fade.sv
// Directed bench for animator_fade: 32-channel instance with 1-cycle buffers
// and a second instance with 3-cycle buffers; buffers are modelled here.
module tb_animator_fade;

    logic        clk = 1'b0;
    logic        rst, drq, drq_b;
    logic [1:0]  mode;
    logic [11:0] step;
    logic [3:0]  shift;

    logic [11:0] tdat, cdat, wdat, tdat_b, cdat_b, wdat_b;
    logic [4:0]  addr, addr_b;
    logic        wen, busy, done, ovr, wen_b, busy_b, done_b, ovr_b;

    logic [11:0] tmem [32];
    logic [11:0] cmem [32];
    logic [11:0] tmem_b [32];
    logic [11:0] cmem_b [32];
    logic [11:0] tp [3];
    logic [11:0] cp [3];

    int vec = 0;
    int errs = 0;
    int wa[$];
    int wd[$];
    int wc[$];
    int done_cyc, busy_cnt, ovr_cnt;

    always #5 clk = ~clk;

    animator_fade #(.c_ledboards(1), .c_rd_lat(1)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_drq(drq), .i_mode(mode), .i_step(step),
        .i_shift(shift), .i_target_data(tdat), .i_current_data(cdat),
        .o_addr(addr), .o_current_wen(wen), .o_current_data(wdat),
        .o_busy(busy), .o_done(done), .o_overrun(ovr));

    animator_fade #(.c_ledboards(1), .c_rd_lat(3)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_drq(drq_b), .i_mode(mode), .i_step(step),
        .i_shift(shift), .i_target_data(tdat_b), .i_current_data(cdat_b),
        .o_addr(addr_b), .o_current_wen(wen_b), .o_current_data(wdat_b),
        .o_busy(busy_b), .o_done(done_b), .o_overrun(ovr_b));

    always @(posedge clk) begin
        tdat <= tmem[addr];
        cdat <= cmem[addr];
        if (wen) cmem[addr] <= wdat;
    end

    always @(posedge clk) begin
        tp[0] <= tmem_b[addr_b];
        tp[1] <= tp[0];
        tp[2] <= tp[1];
        cp[0] <= cmem_b[addr_b];
        cp[1] <= cp[0];
        cp[2] <= cp[1];
        if (wen_b) cmem_b[addr_b] <= wdat_b;
    end
    assign tdat_b = tp[2];
    assign cdat_b = cp[2];

    // Cycle 0 is the cycle drq is sampled; each later cycle is observed at its negedge.
    task automatic run_a(input bit hold, input int mid_mode);
        wa.delete(); wd.delete(); wc.delete();
        done_cyc = -1; busy_cnt = 0; ovr_cnt = 0;
        @(negedge clk); drq = 1'b1;
        @(posedge clk); #1;
        if (!hold) drq = 1'b0;
        for (int c = 1; c <= 1000 && done_cyc < 0; c++) begin
            @(negedge clk);
            if (c == 10 && mid_mode >= 0) begin
                mode = 2'(mid_mode); step = 12'd4095; shift = 4'd0;
            end
            if (wen) begin wa.push_back(int'(addr)); wd.push_back(int'(wdat)); wc.push_back(c); end
            if (busy) busy_cnt++;
            if (ovr) ovr_cnt++;
            if (done) done_cyc = c;
        end
        vec++;
        if (done_cyc < 0) begin errs++; $display("FAIL sweep_timeout: done not seen within 1000 cycles"); end
    endtask

    task automatic test_reset;
        rst = 1'b1; drq = 1'b0; drq_b = 1'b0; mode = 2'd0; step = '0; shift = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vec++; if (addr !== 5'd0)  begin errs++; $display("FAIL reset_addr: got %0d want 0", addr); end
        vec++; if (wen !== 1'b0)   begin errs++; $display("FAIL reset_wen: got %0b want 0", wen); end
        vec++; if (wdat !== 12'd0) begin errs++; $display("FAIL reset_data: got %0d want 0", wdat); end
        vec++; if (busy !== 1'b0 || done !== 1'b0 || ovr !== 1'b0)
            begin errs++; $display("FAIL reset_flags: got busy=%0b done=%0b ovr=%0b want 000", busy, done, ovr); end
        vec++; if (busy_b !== 1'b0 || wen_b !== 1'b0 || addr_b !== 5'd0)
            begin errs++; $display("FAIL reset_b: got busy=%0b wen=%0b addr=%0d want 0 0 0", busy_b, wen_b, addr_b); end
        rst = 1'b0;
    endtask

    task automatic test_snap;
        for (int i = 0; i < 32; i++) begin tmem[i] = 12'(i * 100 + 7); cmem[i] = 12'(4095 - i); end
        mode = 2'd1; step = '0; shift = '0;
        run_a(1'b0, -1);
        vec++; if (wa.size() != 32) begin errs++; $display("FAIL snap_count: got %0d writes want 32", wa.size()); end
        for (int i = 0; i < wa.size() && i < 32; i++) begin
            vec++;
            if (wa[i] != i || wd[i] != i * 100 + 7 || wc[i] != 3 + 3 * i) begin
                errs++;
                $display("FAIL snap_write%0d: got addr=%0d data=%0d cyc=%0d want addr=%0d data=%0d cyc=%0d",
                         i, wa[i], wd[i], wc[i], i, i * 100 + 7, 3 + 3 * i);
            end
        end
        vec++; if (done_cyc != 97) begin errs++; $display("FAIL snap_done_cycle: got %0d want 97", done_cyc); end
        vec++; if (busy_cnt != 96) begin errs++; $display("FAIL snap_busy_cycles: got %0d want 96", busy_cnt); end
        vec++; if (ovr_cnt != 0)   begin errs++; $display("FAIL snap_overrun: got %0d want 0", ovr_cnt); end
    endtask

    task automatic test_linear;
        int exp_up[5] = '{108, 116, 124, 130, 130};
        int exp_dn[4] = '{122, 114, 106, 100};
        for (int i = 0; i < 32; i++) begin tmem[i] = 12'd130; cmem[i] = 12'd100; end
        mode = 2'd0; step = 12'd8; shift = '0;
        for (int f = 0; f < 5; f++) begin
            run_a(1'b0, -1);
            vec++;
            if (wd.size() != 32) begin errs++; $display("FAIL linear_up_count%0d: got %0d want 32", f, wd.size()); end
            else if (wd[0] != exp_up[f] || wd[31] != exp_up[f]) begin
                errs++; $display("FAIL linear_up%0d: got %0d/%0d want %0d", f, wd[0], wd[31], exp_up[f]);
            end
        end
        for (int i = 0; i < 32; i++) tmem[i] = 12'd100;
        for (int f = 0; f < 4; f++) begin
            run_a(1'b0, -1);
            vec++;
            if (wd.size() != 32) begin errs++; $display("FAIL linear_dn_count%0d: got %0d want 32", f, wd.size()); end
            else if (wd[0] != exp_dn[f] || wd[17] != exp_dn[f]) begin
                errs++; $display("FAIL linear_dn%0d: got %0d/%0d want %0d", f, wd[0], wd[17], exp_dn[f]);
            end
        end
        for (int i = 0; i < 32; i++) begin tmem[i] = 12'd300; cmem[i] = 12'd200; end
        step = 12'd0;
        run_a(1'b0, -1);
        vec++;
        if (wd.size() != 32) begin errs++; $display("FAIL step0_count: got %0d want 32", wd.size()); end
        else if (wd[0] != 200 || wd[31] != 200) begin
            errs++; $display("FAIL step0_value: got %0d/%0d want 200", wd[0], wd[31]);
        end
    endtask

    task automatic test_exp;
        int cur_t[5] = '{0, 4094, 2000, 4095, 10};
        int tgt_t[5] = '{4095, 4095, 2000, 0, 8};
        int exp_t[5] = '{1023, 4095, 2000, 3072, 9};
        for (int i = 0; i < 32; i++) begin tmem[i] = 12'd0; cmem[i] = 12'd0; end
        for (int i = 0; i < 5; i++) begin tmem[i] = 12'(tgt_t[i]); cmem[i] = 12'(cur_t[i]); end
        mode = 2'd2; step = '0; shift = 4'd2;
        run_a(1'b0, -1);
        vec++; if (wd.size() != 32) begin errs++; $display("FAIL exp_count: got %0d want 32", wd.size()); end
        for (int i = 0; i < 5 && i < wd.size(); i++) begin
            vec++;
            if (wd[i] != exp_t[i]) begin errs++; $display("FAIL exp_ch%0d: got %0d want %0d", i, wd[i], exp_t[i]); end
        end
    endtask

    task automatic test_limits;
        int cur_t[4] = '{0, 4095, 100, 50};
        int tgt_t[4] = '{4095, 0, 50, 100};
        for (int i = 0; i < 32; i++) begin tmem[i] = 12'd7; cmem[i] = 12'd7; end
        for (int i = 0; i < 4; i++) begin tmem[i] = 12'(tgt_t[i]); cmem[i] = 12'(cur_t[i]); end
        mode = 2'd0; step = 12'd4095; shift = '0;
        run_a(1'b0, -1);
        vec++; if (wd.size() != 32) begin errs++; $display("FAIL limit_count: got %0d want 32", wd.size()); end
        for (int i = 0; i < 4 && i < wd.size(); i++) begin
            vec++;
            if (wd[i] != tgt_t[i]) begin errs++; $display("FAIL limit_ch%0d: got %0d want %0d", i, wd[i], tgt_t[i]); end
        end
        if (wd.size() == 32) begin
            vec++; if (wd[20] != 7) begin errs++; $display("FAIL limit_equal: got %0d want 7", wd[20]); end
        end
    endtask

    // Hold mode with the inputs switched to snap mid-sweep: the latched settings must win.
    task automatic test_hold_freeze;
        for (int i = 0; i < 32; i++) begin tmem[i] = 12'd4000; cmem[i] = 12'(i * 3); end
        mode = 2'd3; step = 12'd50; shift = '0;
        run_a(1'b0, 1);
        vec++; if (wd.size() != 32) begin errs++; $display("FAIL hold_count: got %0d want 32", wd.size()); end
        for (int i = 0; i < wd.size() && i < 32; i += 5) begin
            vec++;
            if (wd[i] != i * 3) begin errs++; $display("FAIL hold_ch%0d: got %0d want %0d", i, wd[i], i * 3); end
        end
    endtask

    task automatic test_back_to_back;
        int nw;
        int seen;
        for (int i = 0; i < 32; i++) begin tmem[i] = 12'(i); cmem[i] = 12'd0; end
        mode = 2'd1; step = '0; shift = '0;
        run_a(1'b1, -1);
        vec++; if (wa.size() != 32)  begin errs++; $display("FAIL b2b_count: got %0d want 32", wa.size()); end
        vec++; if (ovr_cnt != 96)    begin errs++; $display("FAIL b2b_overrun: got %0d want 96", ovr_cnt); end
        vec++; if (done_cyc != 97)   begin errs++; $display("FAIL b2b_done_cycle: got %0d want 97", done_cyc); end
        @(negedge clk);
        vec++;
        if (busy !== 1'b1 || addr !== 5'd0 || ovr !== 1'b0) begin
            errs++; $display("FAIL b2b_restart: got busy=%0b addr=%0d ovr=%0b want 1 0 0", busy, addr, ovr);
        end
        drq = 1'b0;
        nw = 0; seen = 0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            if (wen) nw++;
            if (done) seen = 1;
        end
        vec++;
        if (!seen || nw != 32) begin errs++; $display("FAIL b2b_second: got done=%0d writes=%0d want 1 32", seen, nw); end
    endtask

    task automatic test_reset_mid;
        int nw;
        int nd;
        for (int i = 0; i < 32; i++) begin tmem[i] = 12'(i + 1); cmem[i] = 12'd0; end
        mode = 2'd1;
        @(negedge clk); drq = 1'b1;
        @(posedge clk); #1; drq = 1'b0;
        repeat (31) @(negedge clk);
        vec++; if (addr !== 5'd10 || wen !== 1'b0) begin errs++; $display("FAIL rstmid_pos: got addr=%0d wen=%0b want 10 0", addr, wen); end
        rst = 1'b1;
        @(negedge clk);
        vec++;
        if (busy !== 1'b0 || wen !== 1'b0 || addr !== 5'd0) begin
            errs++; $display("FAIL rstmid_after: got busy=%0b wen=%0b addr=%0d want 0 0 0", busy, wen, addr);
        end
        rst = 1'b0;
        nw = 0; nd = 0;
        for (int c = 0; c < 120; c++) begin
            @(negedge clk);
            if (wen) nw++;
            if (done) nd++;
        end
        vec++; if (nw != 0 || nd != 0) begin errs++; $display("FAIL rstmid_quiet: got writes=%0d done=%0d want 0 0", nw, nd); end
        run_a(1'b0, -1);
        vec++;
        if (wa.size() != 32) begin errs++; $display("FAIL rstmid_restart: got %0d writes want 32", wa.size()); end
        else if (wa[0] != 0 || wd[0] != 1 || wd[31] != 32) begin
            errs++; $display("FAIL rstmid_restart_data: got addr=%0d d0=%0d d31=%0d want 0 1 32", wa[0], wd[0], wd[31]);
        end
    endtask

    task automatic test_lat3;
        int ba[$];
        int bd[$];
        int bc[$];
        int dc;
        for (int i = 0; i < 32; i++) begin tmem_b[i] = 12'(i * 50 + 3); cmem_b[i] = 12'd4000; end
        mode = 2'd1; step = '0; shift = '0;
        dc = -1;
        @(negedge clk); drq_b = 1'b1;
        @(posedge clk); #1; drq_b = 1'b0;
        for (int c = 1; c <= 1000 && dc < 0; c++) begin
            @(negedge clk);
            if (wen_b) begin ba.push_back(int'(addr_b)); bd.push_back(int'(wdat_b)); bc.push_back(c); end
            if (done_b) dc = c;
        end
        vec++; if (dc != 161)      begin errs++; $display("FAIL lat3_done_cycle: got %0d want 161", dc); end
        vec++; if (ba.size() != 32) begin errs++; $display("FAIL lat3_count: got %0d want 32", ba.size()); end
        for (int i = 0; i < ba.size() && i < 32; i += 3) begin
            vec++;
            if (ba[i] != i || bd[i] != i * 50 + 3 || bc[i] != 5 + 5 * i) begin
                errs++;
                $display("FAIL lat3_write%0d: got addr=%0d data=%0d cyc=%0d want addr=%0d data=%0d cyc=%0d",
                         i, ba[i], bd[i], bc[i], i, i * 50 + 3, 5 + 5 * i);
            end
        end
    endtask

    initial begin
        test_reset();
        test_snap();
        test_linear();
        test_exp();
        test_limits();
        test_hold_freeze();
        test_back_to_back();
        test_reset_mid();
        test_lat3();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
